// File: rtl/pdm_capture_sched.sv
`default_nettype none
// ============================================================================
// Module      : pdm_capture_sched
// Description : Capture sequencer between the CIC3 PDM decimator and the
//               TinyQV register/IRQ logic. Gates the microphone clock, waits
//               a warm-up time, discards settling samples, then buffers PCM
//               words in a first-word-fall-through FIFO with a level
//               (watermark) / sticky-overflow interrupt.
// Ports       : clk, rst_n (sync, active-low)
//               start/stop          capture control pulses
//               cfg_warmup/discard/watermark  latched on start
//               pcm_in/pcm_valid    decimator samples
//               rd_en/ovf_clr       CPU pop / overflow clear
//               mic_en, rd_data, rd_valid, fifo_level, overflow,
//               state_o, irq        status outputs
// Config      : define PDM_CAPTURE_AUTOSTOP_EN to return to IDLE when a
//               sample is dropped on a full FIFO during CAPTURE.
// Revision    : 1.0 - initial release
// ============================================================================
module pdm_capture_sched #(
    parameter int DW       = 24,
    parameter int DEPTH    = 8,
    parameter int WARMUP_W = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    stop,
    input  logic [WARMUP_W-1:0]     cfg_warmup,
    input  logic [7:0]              cfg_discard,
    input  logic [$clog2(DEPTH):0]  cfg_watermark,
    input  logic [DW-1:0]           pcm_in,
    input  logic                    pcm_valid,
    input  logic                    rd_en,
    input  logic                    ovf_clr,
    output logic                    mic_en,
    output logic [DW-1:0]           rd_data,
    output logic                    rd_valid,
    output logic [$clog2(DEPTH):0]  fifo_level,
    output logic                    overflow,
    output logic [1:0]              state_o,
    output logic                    irq
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_LW = c_AW + 1;
    localparam logic [c_LW-1:0] c_DEPTH_LV = c_LW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WARMUP  = 2'd1,
        DISCARD = 2'd2,
        CAPTURE = 2'd3
    } state_t;

    state_t                r_state;
    logic                  r_mic_en;
    logic [WARMUP_W-1:0]   r_warm_cnt;
    logic [7:0]            r_disc_cnt;
    logic [c_LW-1:0]       r_wm;

    logic [DW-1:0]         r_mem [DEPTH];
    logic [c_AW-1:0]       r_wr_ptr;
    logic [c_AW-1:0]       r_rd_ptr;
    logic [c_LW-1:0]       r_level;
    logic                  r_overflow;
    logic                  r_irq;

    logic                  w_start_go;
    logic                  w_push_req;
    logic                  w_full;
    logic                  w_pop;
    logic                  w_push_ok;
    logic                  w_ovf_evt;
    logic [c_LW-1:0]       w_wm_eff;

    // stop beats start, so a simultaneous pair in IDLE does nothing
    assign w_start_go = (r_state == IDLE) && start && !stop;
    assign w_push_req = (r_state == CAPTURE) && pcm_valid;
    assign w_full     = (r_level == c_DEPTH_LV);
    assign w_pop      = rd_en && (r_level != '0);
    // a pop in the same cycle frees the slot, so a full FIFO still accepts
    assign w_push_ok  = w_push_req && (!w_full || w_pop);
    assign w_ovf_evt  = w_push_req && w_full && !w_pop;

    assign w_wm_eff = (r_wm == '0)        ? c_LW'(1)   :
                      (r_wm > c_DEPTH_LV) ? c_DEPTH_LV : r_wm;

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_mic_en   <= 1'b0;
            r_warm_cnt <= '0;
            r_disc_cnt <= '0;
            r_wm       <= '0;
        end else if ((r_state != IDLE) && stop) begin
            r_state  <= IDLE;
            r_mic_en <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start_go) begin
                        r_state    <= WARMUP;
                        r_mic_en   <= 1'b1;
                        // a zero warm-up still spends one cycle in WARMUP
                        r_warm_cnt <= (cfg_warmup == '0) ? WARMUP_W'(1) : cfg_warmup;
                        r_disc_cnt <= cfg_discard;
                        r_wm       <= cfg_watermark;
                    end
                end
                WARMUP: begin
                    if (r_warm_cnt <= WARMUP_W'(1)) begin
                        r_warm_cnt <= '0;
                        r_state    <= (r_disc_cnt != 8'd0) ? DISCARD : CAPTURE;
                    end else begin
                        r_warm_cnt <= r_warm_cnt - WARMUP_W'(1);
                    end
                end
                DISCARD: begin
                    if (pcm_valid) begin
                        r_disc_cnt <= r_disc_cnt - 8'd1;
                        if (r_disc_cnt == 8'd1) begin
                            r_state <= CAPTURE;
                        end
                    end
                end
                CAPTURE: begin
`ifdef PDM_CAPTURE_AUTOSTOP_EN
                    if (w_ovf_evt) begin
                        r_state  <= IDLE;
                        r_mic_en <= 1'b0;
                    end
`endif
                end
                default: begin
                    r_state  <= IDLE;
                    r_mic_en <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FIFO storage (no reset needed: rd_data is masked while empty)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= pcm_in;
        end
    end

    // ------------------------------------------------------------------
    // FIFO pointers, level, overflow and interrupt
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
            r_irq      <= 1'b0;
        end else begin
            r_irq <= (r_level >= w_wm_eff) || r_overflow;
            if (w_start_go) begin
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
                r_level    <= '0;
                r_overflow <= 1'b0;
            end else begin
                if (w_push_ok) begin
                    r_wr_ptr <= r_wr_ptr + c_AW'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + c_AW'(1);
                end
                case ({w_push_ok, w_pop})
                    2'b10:   r_level <= r_level + c_LW'(1);
                    2'b01:   r_level <= r_level - c_LW'(1);
                    default: r_level <= r_level;
                endcase
                // setting the sticky flag takes priority over clearing it
                if (w_ovf_evt) begin
                    r_overflow <= 1'b1;
                end else if (ovf_clr) begin
                    r_overflow <= 1'b0;
                end
            end
        end
    end

    assign mic_en     = r_mic_en;
    assign rd_valid   = (r_level != '0);
    assign rd_data    = rd_valid ? r_mem[r_rd_ptr] : '0;
    assign fifo_level = r_level;
    assign overflow   = r_overflow;
    assign state_o    = r_state;
    assign irq        = r_irq;

endmodule
`default_nettype wire
